// File: rtl/sd_data_reader_4bit_if.sv
`default_nettype none
// ============================================================================
// Module      : sd_data_reader_4bit_if
// Description : Bus bundle for the 4-bit SD data block reader: control
//               (ena), card data lines and the received-byte/status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface sd_data_reader_4bit_if #(
  parameter int ADDR_W = 9
);
  logic              ena;
  logic [3:0]        sd_dat;
  logic [7:0]        data_out;
  logic              data_valid;
  logic [ADDR_W-1:0] byte_addr;
  logic              complt;
  logic              crc_err;
  logic              frame_err;
  logic              timeout;

  // Controller / bench side: drives control and card lines, observes results
  modport master (
    output ena, sd_dat,
    input  data_out, data_valid, byte_addr, complt, crc_err, frame_err, timeout
  );

  // Reader side
  modport slave (
    input  ena, sd_dat,
    output data_out, data_valid, byte_addr, complt, crc_err, frame_err, timeout
  );
endinterface
`default_nettype wire

// File: rtl/sd_data_reader_4bit.sv
`default_nettype none
// ============================================================================
// Module      : sd_data_reader_4bit
// Description : Receives one SD data block on DAT[3:0] (start nibble,
//               2*BLOCK_BYTES payload nibbles, CRC_WIDTH CRC bits per line,
//               end nibble) and emits the payload as a byte stream.
//               Optional macro SD_READER_CRC_CHECK_EN builds the per-line
//               CRC16 engines; without it crc_err is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_data_reader_4bit #(
  parameter int BLOCK_BYTES    = 512,
  parameter int CRC_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  wire logic             clk,
  input  wire logic             rstn,
  sd_data_reader_4bit_if.slave  bus
);
  localparam int NIB_COUNT = 2 * BLOCK_BYTES;
  localparam int NW        = $clog2(NIB_COUNT);
  localparam int AW        = $clog2(BLOCK_BYTES);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_DATA       = 3'd2;
  localparam logic [2:0] ST_CRC        = 3'd3;
  localparam logic [2:0] ST_END        = 3'd4;
  localparam logic [2:0] ST_DONE       = 3'd5;

  logic [2:0]    state;
  logic [NW-1:0] nib_cnt;    // payload nibble index, reused as CRC bit index
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_next;
  logic [3:0]    hi_nib;
  logic [7:0]    data_out;
  logic          data_valid;
  logic [AW-1:0] byte_addr;
  logic          complt;
  logic          frame_err;
  logic          timeout;

  assign tmo_next = tmo_cnt + TW'(1);

  // Frame sequencer: start detection, nibble pairing, CRC/end-bit timing
  always_ff @(posedge clk) begin
    if (!rstn || !bus.ena) begin
      state      <= ST_IDLE;
      nib_cnt    <= '0;
      tmo_cnt    <= '0;
      hi_nib     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      byte_addr  <= '0;
      complt     <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          // Only an all-low bus is a start bit; partial lows keep waiting
          if (bus.sd_dat == 4'h0) begin
            nib_cnt <= '0;
            state   <= ST_DATA;
          end else begin
            tmo_cnt <= tmo_next;
            if (tmo_next == TW'(TIMEOUT_CYCLES)) begin
              timeout <= 1'b1;
              complt  <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_DATA: begin
          if (!nib_cnt[0]) begin
            hi_nib <= bus.sd_dat;
          end else begin
            data_out   <= {hi_nib, bus.sd_dat};
            byte_addr  <= nib_cnt[NW-1:1];
            data_valid <= 1'b1;
          end
          if (nib_cnt == NW'(NIB_COUNT - 1)) begin
            nib_cnt <= '0;
            state   <= ST_CRC;
          end else begin
            nib_cnt <= nib_cnt + NW'(1);
          end
        end
        ST_CRC: begin
          // Runs the full CRC length even when checking is not built
          if (nib_cnt == NW'(CRC_WIDTH - 1)) begin
            nib_cnt <= '0;
            state   <= ST_END;
          end else begin
            nib_cnt <= nib_cnt + NW'(1);
          end
        end
        ST_END: begin
          frame_err <= (bus.sd_dat != 4'hF);
          complt    <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          // Hold results until ena drops
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.byte_addr  = byte_addr;
  assign bus.complt     = complt;
  assign bus.frame_err  = frame_err;
  assign bus.timeout    = timeout;

`ifdef SD_READER_CRC_CHECK_EN
  localparam logic [CRC_WIDTH-1:0] CRC_POLY = CRC_WIDTH'(16'h1021);

  logic [3:0] line_mismatch;
  logic       crc_err;

  for (genvar i = 0; i < 4; i++) begin : g_crc_line
    logic [CRC_WIDTH-1:0] calc_crc;
    logic [CRC_WIDTH-1:0] rx_crc;
    logic                 feedback;

    assign feedback = calc_crc[CRC_WIDTH-1] ^ bus.sd_dat[i];

    // Serial CRC over the payload bits of this line, then capture of the sent CRC
    always_ff @(posedge clk) begin
      if (!rstn || !bus.ena) begin
        calc_crc <= '0;
        rx_crc   <= '0;
      end else if (state == ST_WAIT_START && bus.sd_dat == 4'h0) begin
        calc_crc <= '0;
        rx_crc   <= '0;
      end else if (state == ST_DATA) begin
        calc_crc <= {calc_crc[CRC_WIDTH-2:0], 1'b0} ^ (feedback ? CRC_POLY : '0);
      end else if (state == ST_CRC) begin
        rx_crc <= {rx_crc[CRC_WIDTH-2:0], bus.sd_dat[i]};
      end
    end

    assign line_mismatch[i] = (calc_crc != rx_crc);
  end

  // Latch the combined CRC verdict together with the end bit
  always_ff @(posedge clk) begin
    if (!rstn || !bus.ena) begin
      crc_err <= 1'b0;
    end else if (state == ST_END) begin
      crc_err <= |line_mismatch;
    end
  end

  assign bus.crc_err = crc_err;
`else
  assign bus.crc_err = 1'b0;
`endif
endmodule
`default_nettype wire
